// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - scanned active-low seven-segment bus back to BCD digits
// Synchronizes the pads, debounces each {an_n, seg_n} pattern, decodes and assembles frames.
module seg_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_DIGITS-1:0]     an_n,
  input  logic [6:0]                seg_n,
  output logic [4*NUM_DIGITS-1:0]   digits,
  output logic [NUM_DIGITS-1:0]     digit_valid,
  output logic                      frame_valid,
  output logic                      frame_pulse,
  output logic                      code_error
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HOLD} state_t;

  logic [NUM_DIGITS-1:0]   an_s1, an_s2;
  logic [6:0]              seg_s1, seg_s2;
  logic [NUM_DIGITS+6:0]   sample, prev_q;
  logic                    changed, idle_an;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d, cnt_inc;
  logic                    accept;

  logic [NUM_DIGITS-1:0]   an_low, seen_q, seen_d, dv_d;
  logic [4*NUM_DIGITS-1:0] dig_d;
  logic                    onehot, dec_ok, blank, fv_d, fp_d, ce_d;
  logic [3:0]              dec_val;

  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    case (s)
      7'b1000000: decode_seg = {1'b1, 4'd0};
      7'b1111001: decode_seg = {1'b1, 4'd1};
      7'b0100100: decode_seg = {1'b1, 4'd2};
      7'b0110000: decode_seg = {1'b1, 4'd3};
      7'b0011001: decode_seg = {1'b1, 4'd4};
      7'b0010010: decode_seg = {1'b1, 4'd5};
      7'b0000010: decode_seg = {1'b1, 4'd6};
      7'b1111000: decode_seg = {1'b1, 4'd7};
      7'b0000000: decode_seg = {1'b1, 4'd8};
      7'b0010000: decode_seg = {1'b1, 4'd9};
      default:    decode_seg = {1'b0, 4'd0};
    endcase
  endfunction

  // Pads reset to the idle (all ones) bus so release never looks like a pattern.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an_s1  <= '1;
      an_s2  <= '1;
      seg_s1 <= '1;
      seg_s2 <= '1;
      prev_q <= '1;
    end else begin
      an_s1  <= an_n;
      an_s2  <= an_s1;
      seg_s1 <= seg_n;
      seg_s2 <= seg_s1;
      prev_q <= sample;
    end
  end

  assign sample  = {an_s2, seg_s2};
  assign changed = (sample != prev_q);
  assign idle_an = &an_s2;
  assign cnt_inc = cnt_q + CW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    if (changed) begin
      if (idle_an) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else if (CNT_MAX == CW'(1)) begin
        state_d = ST_HOLD;
        cnt_d   = CNT_MAX;
        accept  = 1'b1;
      end else begin
        state_d = ST_SETTLE;
        cnt_d   = CW'(1);
      end
    end else begin
      case (state_q)
        ST_IDLE: cnt_d = '0;
        ST_SETTLE: begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            state_d = ST_HOLD;
            accept  = 1'b1;
          end
        end
        ST_HOLD: cnt_d = CNT_MAX;
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign an_low            = ~an_s2;
  assign onehot            = (an_low != '0) && ((an_low & (an_low - NUM_DIGITS'(1))) == '0);
  assign {dec_ok, dec_val} = decode_seg(seg_s2);
  assign blank             = &seg_s2;

  // Accepted pattern: update the selected digit, then close the frame once every digit is seen.
  always_comb begin
    dig_d  = digits;
    dv_d   = digit_valid;
    seen_d = seen_q;
    fv_d   = frame_valid;
    fp_d   = 1'b0;
    ce_d   = 1'b0;
    if (accept) begin
      if (onehot) begin
        ce_d = !dec_ok && !blank;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (an_low[i]) begin
            seen_d[i] = 1'b1;
            dv_d[i]   = dec_ok;
            if (dec_ok) dig_d[4*i +: 4] = dec_val;
          end
        end
        if (&seen_d) begin
          fp_d   = 1'b1;
          seen_d = '0;
          fv_d   = &dv_d;
        end
      end else begin
        ce_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digits      <= '0;
      digit_valid <= '0;
      seen_q      <= '0;
      frame_valid <= 1'b0;
      frame_pulse <= 1'b0;
      code_error  <= 1'b0;
    end else begin
      digits      <= dig_d;
      digit_valid <= dv_d;
      seen_q      <= seen_d;
      frame_valid <= fv_d;
      frame_pulse <= fp_d;
      code_error  <= ce_d;
    end
  end

endmodule
